// File: rtl/vec_cnt_collector.sv
// vec_cnt_collector
//   Reassembles a wide fingerprint vector from a stream of BUS_WIDTH-bit
//   sub-vector words and presents it, together with its popcount and
//   batch-last flag, on a valid/ready output register.
//
//   Ports:
//     clk, rst        : single clock, synchronous active-high reset
//     up_SubVector    : incoming sub-vector word (word 0 is least significant)
//     up_Valid        : up_SubVector valid
//     up_Cnt          : vector popcount, meaningful on the final word
//     up_CntNew       : upstream marker of the final word (checked only)
//     up_Last         : final word of the final vector of a batch
//     up_Ready        : word accepted when up_Valid && up_Ready
//     dn_Vector       : reassembled vector
//     dn_Cnt          : popcount captured with the vector
//     dn_Valid        : dn_Vector/dn_Cnt/dn_Last valid
//     dn_Last         : vector is the last of its batch
//     dn_Ready        : downstream accepts when dn_Valid && dn_Ready
//     dn_ProtoErr     : sticky upstream protocol error flag
//
//   Build option: define VEC_CNT_COLLECTOR_CHECK_EN to include the upstream
//   protocol checker driving dn_ProtoErr; otherwise dn_ProtoErr is tied low.
module vec_cnt_collector #(
    parameter int unsigned VECTOR_WIDTH  = 920,
    parameter int unsigned BUS_WIDTH     = 128,
    parameter int unsigned SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    parameter int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    up_SubVector,
    input  logic                    up_Valid,
    input  logic [CNT_WIDTH-1:0]    up_Cnt,
    input  logic                    up_CntNew,
    input  logic                    up_Last,
    output logic                    up_Ready,
    output logic [VECTOR_WIDTH-1:0] dn_Vector,
    output logic [CNT_WIDTH-1:0]    dn_Cnt,
    output logic                    dn_Valid,
    output logic                    dn_Last,
    input  logic                    dn_Ready,
    output logic                    dn_ProtoErr
);

    localparam int unsigned IDX_W = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUB_VECTOR_NO - 1);

    logic [IDX_W-1:0]        idx_q,  idx_d;
    logic [VECTOR_WIDTH-1:0] asm_q,  asm_d;
    logic [VECTOR_WIDTH-1:0] vec_q,  vec_d;
    logic [CNT_WIDTH-1:0]    cnt_q,  cnt_d;
    logic                    last_q, last_d;
    logic                    val_q,  val_d;

    logic                    final_word;
    logic                    accept;
    logic                    transfer;

    // With SUB_VECTOR_NO == 1 the index is pinned at 0, so every word is final.
    assign final_word = (idx_q == LAST_IDX);
    // Only the final word needs the output register; earlier words may be
    // absorbed while a previous vector is still stalled downstream.
    assign up_Ready   = !(final_word && val_q && !dn_Ready);
    assign accept     = up_Valid && up_Ready;
    assign transfer   = accept && final_word;

    // Per-bit word placement with constant indices; bits of the final word
    // beyond VECTOR_WIDTH have no destination and are dropped.
    for (genvar g = 0; g < VECTOR_WIDTH; g++) begin : g_bit
        localparam int unsigned WORD = g / BUS_WIDTH;
        assign asm_d[g] = (accept && idx_q == IDX_W'(WORD))
                          ? up_SubVector[g % BUS_WIDTH] : asm_q[g];
    end

    always_comb begin
        idx_d  = idx_q;
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        val_d  = val_q;

        if (accept) begin
            idx_d = final_word ? '0 : idx_q + IDX_W'(1);
        end

        if (transfer) begin
            // asm_d already contains the final word, so the vector lands in
            // the output register on the same edge the word is accepted.
            vec_d  = asm_d;
            cnt_d  = up_Cnt;
            last_d = up_Last;
            val_d  = 1'b1;
        end else if (dn_Ready) begin
            val_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            asm_q  <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
            val_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            val_q  <= val_d;
        end
    end

    assign dn_Vector = vec_q;
    assign dn_Cnt    = cnt_q;
    assign dn_Last   = last_q;
    assign dn_Valid  = val_q;

`ifdef VEC_CNT_COLLECTOR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && ((up_CntNew != final_word) || (up_Last && !final_word))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign dn_ProtoErr = err_q;
`else
    assign dn_ProtoErr = 1'b0;
`endif

endmodule
